// File: rtl/upsampling_engine_if.sv
// Bus between the 2x horizontal upsampler and its surroundings.
// The sequencer uses start/mode/busy/done and the SRAM uses raddr/rdata/waddr/wdata/wr_enable.
interface upsampling_engine_if #(
  parameter int DW = 16,
  parameter int AW = 18
);
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wr_enable;

  // Sequencer and SRAM side
  modport master (
    output start, mode, rdata,
    input  busy, done, raddr, waddr, wdata, wr_enable
  );

  // Engine side
  modport slave (
    input  start, mode, rdata,
    output busy, done, raddr, waddr, wdata, wr_enable
  );
endinterface

// File: rtl/upsampling_engine.sv
// Horizontal 2x upsampler. It streams NCH planes of W x H samples from SRAM and
// writes 2W x H planes back, using linear interpolation or replication.
// Each row runs PRIME (2 cycles), RUN (2W cycles, one write per cycle) and ROW_END (1 cycle).
// Reads are issued one column ahead, so in[i+1] arrives just before output 2i+1 needs it.
module upsampling_engine #(
  parameter int W               = 160,
  parameter int H               = 120,
  parameter int DW              = 16,
  parameter int AW              = 18,
  parameter int NCH             = 2,
  parameter int READ_ADDR_BASE  = 0,
  parameter int WRITE_ADDR_BASE = 38400
) (
  input  logic                 clk,
  input  logic                 reset,
  upsampling_engine_if.slave   bus
);

  localparam int ROWS = NCH * H;
  localparam int KW   = $clog2(2 * W + 1);
  localparam int RCW  = $clog2(ROWS + 1);

  localparam logic [AW-1:0]  RD_BASE   = AW'(READ_ADDR_BASE);
  localparam logic [AW-1:0]  WR_BASE   = AW'(WRITE_ADDR_BASE);
  localparam logic [AW-1:0]  RD_STEP   = AW'(W);
  localparam logic [AW-1:0]  WR_STEP   = AW'(2 * W);
  localparam logic [KW-1:0]  K_LAST    = KW'(2 * W - 1);
  localparam logic [RCW-1:0] ROWS_LAST = RCW'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, ROW_END, FIN} state_t;

  state_t         state_reg, state_next;
  logic           mode_reg;
  logic           prime_ph_reg;
  logic [KW-1:0]  k_reg;
  logic [RCW-1:0] row_cnt_reg;
  logic [AW-1:0]  rd_row_base_reg;
  logic [AW-1:0]  wr_row_base_reg;
  logic [AW-1:0]  raddr_reg;
  logic [AW-1:0]  waddr_reg;
  logic [DW-1:0]  wdata_reg;
  logic           wr_en_reg;
  logic [DW-1:0]  cur_reg;
  logic [DW-1:0]  nxt_reg;

  logic [DW:0]    sum;
  logic [DW-1:0]  out_sample;
  logic           read_more;

  // The average is formed DW+1 bits wide, so the rounded result never wraps
  assign sum = {1'b0, cur_reg} + {1'b0, nxt_reg} + (DW + 1)'(1);

  // Fetch column i+2 while output 2i is formed, as long as that column exists
  assign read_more = (int'(k_reg) + 6) <= (2 * W);

  // Select the output sample: even k copies in[i], odd k interpolates except at the right edge
  always_comb begin
    out_sample = cur_reg;
    if (k_reg[0] && !mode_reg && (k_reg != K_LAST)) begin
      out_sample = DW'(sum >> 1);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = PRIME;
      PRIME:   if (prime_ph_reg) state_next = RUN;
      RUN:     if (k_reg == K_LAST) state_next = ROW_END;
      ROW_END: state_next = (row_cnt_reg == ROWS_LAST) ? FIN : PRIME;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any run immediately
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Address generation, read pipeline and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg        <= 1'b0;
      prime_ph_reg    <= 1'b0;
      k_reg           <= '0;
      row_cnt_reg     <= '0;
      rd_row_base_reg <= '0;
      wr_row_base_reg <= '0;
      raddr_reg       <= '0;
      waddr_reg       <= '0;
      wdata_reg       <= '0;
      wr_en_reg       <= 1'b0;
      cur_reg         <= '0;
      nxt_reg         <= '0;
    end else begin
      wr_en_reg <= (state_reg == RUN);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            mode_reg        <= bus.mode;
            raddr_reg       <= RD_BASE;
            rd_row_base_reg <= RD_BASE;
            wr_row_base_reg <= WR_BASE;
            row_cnt_reg     <= '0;
            prime_ph_reg    <= 1'b0;
          end
        end
        PRIME: begin
          if (!prime_ph_reg) begin
            prime_ph_reg <= 1'b1;
            if (W > 1) raddr_reg <= raddr_reg + AW'(1);
          end else begin
            prime_ph_reg <= 1'b0;
            cur_reg      <= bus.rdata;
            k_reg        <= '0;
          end
        end
        RUN: begin
          wdata_reg <= out_sample;
          waddr_reg <= wr_row_base_reg + AW'(k_reg);
          k_reg     <= k_reg + KW'(1);
          if (!k_reg[0]) begin
            nxt_reg <= bus.rdata;
            if (read_more) raddr_reg <= raddr_reg + AW'(1);
          end else begin
            cur_reg <= nxt_reg;
          end
        end
        ROW_END: begin
          row_cnt_reg     <= row_cnt_reg + RCW'(1);
          rd_row_base_reg <= rd_row_base_reg + RD_STEP;
          wr_row_base_reg <= wr_row_base_reg + WR_STEP;
          if (row_cnt_reg != ROWS_LAST) raddr_reg <= rd_row_base_reg + RD_STEP;
        end
        default: ;
      endcase
    end
  end

  // Status and write strobe are masked by reset so an aborted run writes nothing in the reset cycle
  assign bus.busy      = !reset && (state_reg != IDLE) && (state_reg != FIN);
  assign bus.done      = !reset && (state_reg == FIN);
  assign bus.wr_enable = !reset && wr_en_reg;
  assign bus.raddr     = raddr_reg;
  assign bus.waddr     = waddr_reg;
  assign bus.wdata     = wdata_reg;

endmodule

// File: tb/tb_upsampling_engine.sv
// Scoreboard bench for upsampling_engine. There are three instances with different geometries.
// Stimulus pushes the expected writes into queues, and a forked monitor pops them and compares.
module tb_upsampling_engine;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  upsampling_engine_if #(.DW(16), .AW(18)) ifa ();
  upsampling_engine_if #(.DW(16), .AW(18)) ifb ();
  upsampling_engine_if #(.DW(16), .AW(18)) ifc ();

  upsampling_engine #(.W(4), .H(1), .DW(16), .AW(18), .NCH(1),
                      .READ_ADDR_BASE(0), .WRITE_ADDR_BASE(100)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  upsampling_engine #(.W(2), .H(2), .DW(16), .AW(18), .NCH(2),
                      .READ_ADDR_BASE(0), .WRITE_ADDR_BASE(64)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));
  upsampling_engine #(.W(1), .H(3), .DW(16), .AW(18), .NCH(1),
                      .READ_ADDR_BASE(0), .WRITE_ADDR_BASE(20)) u_c (
    .clk(clk), .reset(reset), .bus(ifc.slave));

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [15:0] mem_c [0:255];

  // Synchronous-read SRAM models: data appears one cycle after the address
  always @(posedge clk) begin
    ifa.rdata <= mem_a[ifa.raddr[7:0]];
    ifb.rdata <= mem_b[ifb.raddr[7:0]];
    ifc.rdata <= mem_c[ifc.raddr[7:0]];
  end

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t q_c[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  wr_cnt_a = 0, wr_cnt_b = 0, wr_cnt_c = 0;
  int  done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [17:0] addr);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected write at %0d, expected none", nm, addr);
  endtask

  // Monitor: every write is popped against the scoreboard in issue order
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (ifa.wr_enable) begin
        wr_cnt_a++;
        if (q_a.size() == 0) unexpected("a_write", ifa.waddr);
        else begin
          e = q_a.pop_front();
          check("a_waddr", 32'(ifa.waddr), 32'(e.addr));
          check("a_wdata", 32'(ifa.wdata), 32'(e.data));
          $display("a write addr=%0d data=%0h", ifa.waddr, ifa.wdata);
        end
      end
      if (ifb.wr_enable) begin
        wr_cnt_b++;
        if (q_b.size() == 0) unexpected("b_write", ifb.waddr);
        else begin
          e = q_b.pop_front();
          check("b_waddr", 32'(ifb.waddr), 32'(e.addr));
          check("b_wdata", 32'(ifb.wdata), 32'(e.data));
          $display("b write addr=%0d data=%0h", ifb.waddr, ifb.wdata);
        end
      end
      if (ifc.wr_enable) begin
        wr_cnt_c++;
        if (q_c.size() == 0) unexpected("c_write", ifc.waddr);
        else begin
          e = q_c.pop_front();
          check("c_waddr", 32'(ifc.waddr), 32'(e.addr));
          check("c_wdata", 32'(ifc.wdata), 32'(e.data));
          $display("c write addr=%0d data=%0h", ifc.waddr, ifc.wdata);
        end
      end
      if (ifa.done) done_cnt_a++;
      if (ifb.done) done_cnt_b++;
      if (ifc.done) done_cnt_c++;
    end
  endtask

  task automatic exp8_a(input logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7, input int n);
    logic [15:0] v [8];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < n; i++) q_a.push_back('{addr: 18'(100 + i), data: v[i]});
  endtask

  // One complete run on instance A with latency, busy, done and write-count checks
  task automatic run_a(input logic m, input logic toggle, input string nm);
    int first, dcyc;
    first = -1;
    dcyc = -1;
    wr_cnt_a = 0;
    done_cnt_a = 0;
    @(posedge clk); #1 ifa.start = 1'b1; ifa.mode = m;
    @(posedge clk); #1 ifa.start = 1'b0;
    if (toggle) ifa.mode = ~m;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check({nm, "_busy_after_start"}, 32'(ifa.busy), 32'd1);
      if (ifa.wr_enable && first < 0) first = cyc;
      if (ifa.done) begin
        dcyc = cyc;
        check({nm, "_busy_at_done"}, 32'(ifa.busy), 32'd0);
        break;
      end
    end
    check({nm, "_first_write_by_4"}, 32'(first >= 1 && first <= 4), 32'd1);
    check({nm, "_done_by_bound"}, 32'(dcyc >= 1 && dcyc <= 17), 32'd1);
    repeat (3) @(negedge clk);
    check({nm, "_write_count"}, 32'(wr_cnt_a), 32'd8);
    check({nm, "_done_pulses"}, 32'(done_cnt_a), 32'd1);
    check({nm, "_queue_left"}, 32'(q_a.size()), 32'd0);
    $display("%s: first write cycle %0d, done cycle %0d", nm, first, dcyc);
  endtask

  initial begin
    int seen;
    ifa.start = 0; ifa.mode = 0;
    ifb.start = 0; ifb.mode = 0;
    ifc.start = 0; ifc.mode = 0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(ifa.busy), 32'd0);
    check("reset_done", 32'(ifa.done), 32'd0);
    check("reset_wr_enable", 32'(ifa.wr_enable), 32'd0);
    check("reset_raddr", 32'(ifa.raddr), 32'd0);
    check("reset_waddr", 32'(ifa.waddr), 32'd0);
    check("reset_wdata", 32'(ifa.wdata), 32'd0);
    #1 reset = 1'b0;

    // Linear interpolation
    mem_a[0] = 16'd10; mem_a[1] = 16'd20; mem_a[2] = 16'd30; mem_a[3] = 16'd40;
    exp8_a(10, 15, 20, 25, 30, 35, 40, 40, 8);
    run_a(1'b0, 1'b0, "linear");

    // Replicate mode, with the mode pin flipped after start
    exp8_a(10, 10, 20, 20, 30, 30, 40, 40, 8);
    run_a(1'b1, 1'b1, "replicate");

    // Rounding and no overflow: (31+0xFFFF+1)>>1 = 0x800F
    mem_a[0] = 16'd20; mem_a[1] = 16'd31; mem_a[2] = 16'hFFFF; mem_a[3] = 16'hFFFF;
    exp8_a(20, 26, 31, 16'h800F, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8);
    run_a(1'b0, 1'b0, "rounding");

    // Multi-plane W=2 H=2 NCH=2 with a stray start mid-run
    mem_b[0] = 1;   mem_b[1] = 3;   mem_b[2] = 5; mem_b[3] = 9;
    mem_b[4] = 100; mem_b[5] = 200; mem_b[6] = 7; mem_b[7] = 8;
    begin
      logic [15:0] vb [16];
      vb = '{1, 2, 3, 3, 5, 7, 9, 9, 100, 150, 200, 200, 7, 8, 8, 8};
      for (int i = 0; i < 16; i++) q_b.push_back('{addr: 18'(64 + i), data: vb[i]});
    end
    wr_cnt_b = 0;
    done_cnt_b = 0;
    @(posedge clk); #1 ifb.start = 1'b1;
    @(posedge clk); #1 ifb.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 ifb.start = 1'b1;
    @(posedge clk); #1 ifb.start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 80 && seen == 0; cyc++) begin
      @(negedge clk);
      if (ifb.done) seen = 1;
    end
    check("multi_done_seen", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    check("multi_write_count", 32'(wr_cnt_b), 32'd16);
    check("multi_done_pulses", 32'(done_cnt_b), 32'd1);
    check("multi_queue_left", 32'(q_b.size()), 32'd0);

    // Single-column rows: W=1 H=3
    mem_c[0] = 5; mem_c[1] = 6; mem_c[2] = 7;
    begin
      logic [15:0] vc [6];
      vc = '{5, 5, 6, 6, 7, 7};
      for (int i = 0; i < 6; i++) q_c.push_back('{addr: 18'(20 + i), data: vc[i]});
    end
    wr_cnt_c = 0;
    @(posedge clk); #1 ifc.start = 1'b1; ifc.mode = 1'b0;
    @(posedge clk); #1 ifc.start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 60 && seen == 0; cyc++) begin
      @(negedge clk);
      if (ifc.done) seen = 1;
    end
    check("w1_done_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("w1_write_count", 32'(wr_cnt_c), 32'd6);
    check("w1_queue_left", 32'(q_c.size()), 32'd0);

    // Reset on the 5th write aborts: only the first 4 writes may appear
    mem_a[0] = 16'd10; mem_a[1] = 16'd20; mem_a[2] = 16'd30; mem_a[3] = 16'd40;
    exp8_a(10, 15, 20, 25, 30, 35, 40, 40, 4);
    @(posedge clk); #1 ifa.start = 1'b1; ifa.mode = 1'b0;
    @(posedge clk); #1 ifa.start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
      @(negedge clk);
      if (ifa.wr_enable) seen++;
    end
    check("abort_four_writes_seen", 32'(seen), 32'd4);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_wr_enable", 32'(ifa.wr_enable), 32'd0);
    check("abort_busy", 32'(ifa.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_wr_enable_after", 32'(ifa.wr_enable), 32'd0);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_queue_left", 32'(q_a.size()), 32'd0);

    // A fresh run after the abort completes normally
    exp8_a(10, 15, 20, 25, 30, 35, 40, 40, 8);
    run_a(1'b0, 1'b0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
